// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port sequencer: clears x1..xN-1 after reset, then round-robins ALU/LSU writebacks.
// Latency: 1 cycle from a valid&&ready transfer to we_o/rd_addr_o/rd_o.
// Backpressure: ready is low during the clear; afterwards one requester is granted per cycle, alternating on ties.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTER  = 32,
  parameter int INIT_ON_RESET = 1,
  localparam int AW           = $clog2(NUM_REGISTER)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [AW-1:0]         a_addr_i,
  input  logic [DATA_WIDTH-1:0] a_data_i,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [AW-1:0]         b_addr_i,
  input  logic [DATA_WIDTH-1:0] b_data_i,
  output logic                  we_o,
  output logic [AW-1:0]         rd_addr_o,
  output logic [DATA_WIDTH-1:0] rd_o,
  output logic                  init_done_o,
  output logic                  conflict_o
);

  typedef enum logic {S_INIT, S_ARB} state_t;

  localparam logic [AW-1:0] LAST_REG = AW'(NUM_REGISTER - 1);

  state_t        state;
  logic          last_b;    // 1 = B held the most recent grant
  logic [AW-1:0] init_cnt;
  logic          grant_a;
  logic          grant_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == S_ARB) begin
      grant_a = a_valid_i && (!b_valid_i || last_b);
      grant_b = b_valid_i && !grant_a;
    end
  end

  assign a_ready_o = grant_a;
  assign b_ready_o = grant_b;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= (INIT_ON_RESET != 0) ? S_INIT : S_ARB;
      last_b      <= 1'b1;
      init_cnt    <= AW'(1);
      we_o        <= 1'b0;
      rd_addr_o   <= '0;
      rd_o        <= '0;
      init_done_o <= 1'b0;
      conflict_o  <= 1'b0;
    end else if (state == S_INIT) begin
      we_o       <= 1'b1;
      rd_addr_o  <= init_cnt;
      rd_o       <= '0;
      conflict_o <= 1'b0;
      // Stop counting at the last register so the counter never wraps.
      if (init_cnt == LAST_REG) begin
        state       <= S_ARB;
        init_done_o <= 1'b1;
      end else begin
        init_cnt <= init_cnt + 1'b1;
      end
    end else begin
      init_done_o <= 1'b1;
      conflict_o  <= a_valid_i && b_valid_i;
      we_o        <= 1'b0;
      // x0 transfers are acknowledged but never reach the write port.
      if (grant_a) begin
        last_b <= 1'b0;
        if (a_addr_i != '0) begin
          we_o      <= 1'b1;
          rd_addr_o <= a_addr_i;
          rd_o      <= a_data_i;
        end
      end else if (grant_b) begin
        last_b <= 1'b1;
        if (b_addr_i != '0) begin
          we_o      <= 1'b1;
          rd_addr_o <= b_addr_i;
          rd_o      <= b_data_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: clear sequence, grants, x0 suppression, ties, reset mid-clear.
// Inputs change 1 time unit after the rising edge; outputs are sampled there or 1 unit later.
module tb_regfile_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          a_valid_i, b_valid_i;
  logic          a_ready_o, b_ready_o;
  logic [AW-1:0] a_addr_i, b_addr_i;
  logic [DW-1:0] a_data_i, b_data_i;
  logic          we_o;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_o;
  logic          init_done_o;
  logic          conflict_o;

  int n_total = 0;
  int n_pass  = 0;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REGISTER(32), .INIT_ON_RESET(1)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_addr_i(a_addr_i), .a_data_i(a_data_i),
    .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_addr_i(b_addr_i), .b_data_i(b_data_i),
    .we_o(we_o), .rd_addr_o(rd_addr_o), .rd_o(rd_o),
    .init_done_o(init_done_o), .conflict_o(conflict_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0;
    a_valid_i = 0; b_valid_i = 0;
    a_addr_i = '0; b_addr_i = '0; a_data_i = '0; b_data_i = '0;
    tick; tick;
    n_total++; if (we_o !== 1'b0) $display("FAIL reset_we got %b exp 0", we_o); else n_pass++;
    n_total++; if (rd_addr_o !== 5'd0) $display("FAIL reset_addr got %0d exp 0", rd_addr_o); else n_pass++;
    n_total++; if (rd_o !== 32'd0) $display("FAIL reset_data got %h exp 0", rd_o); else n_pass++;
    n_total++; if (init_done_o !== 1'b0) $display("FAIL reset_done got %b exp 0", init_done_o); else n_pass++;
    n_total++; if (conflict_o !== 1'b0) $display("FAIL reset_conflict got %b exp 0", conflict_o); else n_pass++;
    n_total++; if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0)
      $display("FAIL reset_ready got a=%b b=%b exp 0 0", a_ready_o, b_ready_o); else n_pass++;
    rst_n_i = 1'b1;
  endtask

  task automatic test_init;
    for (int i = 1; i <= 31; i++) begin
      tick;
      n_total++; if (we_o !== 1'b1 || rd_addr_o !== 5'(i) || rd_o !== 32'd0)
        $display("FAIL init_write i=%0d got we=%b addr=%0d data=%h exp 1 %0d 0", i, we_o, rd_addr_o, rd_o, i);
      else n_pass++;
      n_total++; if (init_done_o !== (i == 31))
        $display("FAIL init_done i=%0d got %b exp %b", i, init_done_o, (i == 31)); else n_pass++;
    end
    tick;
    n_total++; if (we_o !== 1'b0 || init_done_o !== 1'b1)
      $display("FAIL init_end got we=%b done=%b exp 0 1", we_o, init_done_o); else n_pass++;
  endtask

  task automatic test_single_a;
    a_valid_i = 1; a_addr_i = 5'd5; a_data_i = 32'hDEADBEEF;
    #1;
    n_total++; if (a_ready_o !== 1'b1 || b_ready_o !== 1'b0)
      $display("FAIL single_a_ready got a=%b b=%b exp 1 0", a_ready_o, b_ready_o); else n_pass++;
    tick;
    a_valid_i = 0;
    n_total++; if (we_o !== 1'b1 || rd_addr_o !== 5'd5 || rd_o !== 32'hDEADBEEF)
      $display("FAIL single_a_write got we=%b addr=%0d data=%h exp 1 5 deadbeef", we_o, rd_addr_o, rd_o);
    else n_pass++;
    n_total++; if (conflict_o !== 1'b0) $display("FAIL single_a_conflict got %b exp 0", conflict_o); else n_pass++;
    tick;
    n_total++; if (we_o !== 1'b0 || rd_addr_o !== 5'd5)
      $display("FAIL single_a_idle got we=%b addr=%0d exp 0 5", we_o, rd_addr_o); else n_pass++;
  endtask

  task automatic test_zero_addr;
    b_valid_i = 1; b_addr_i = 5'd0; b_data_i = 32'hFFFFFFFF;
    #1;
    n_total++; if (b_ready_o !== 1'b1 || a_ready_o !== 1'b0)
      $display("FAIL zero_ready got a=%b b=%b exp 0 1", a_ready_o, b_ready_o); else n_pass++;
    tick;
    b_valid_i = 0;
    n_total++; if (we_o !== 1'b0) $display("FAIL zero_we got %b exp 0", we_o); else n_pass++;
  endtask

  task automatic test_tie;
    a_valid_i = 1; a_addr_i = 5'd1; a_data_i = 32'h11;
    b_valid_i = 1; b_addr_i = 5'd2; b_data_i = 32'h22;
    #1;
    n_total++; if (a_ready_o !== 1'b1 || b_ready_o !== 1'b0)
      $display("FAIL tie_first got a=%b b=%b exp 1 0", a_ready_o, b_ready_o); else n_pass++;
    tick;
    a_valid_i = 0;
    n_total++; if (we_o !== 1'b1 || rd_addr_o !== 5'd1 || rd_o !== 32'h11)
      $display("FAIL tie_write_a got we=%b addr=%0d data=%h exp 1 1 11", we_o, rd_addr_o, rd_o); else n_pass++;
    n_total++; if (conflict_o !== 1'b1) $display("FAIL tie_conflict got %b exp 1", conflict_o); else n_pass++;
    #1;
    n_total++; if (b_ready_o !== 1'b1) $display("FAIL tie_second got %b exp 1", b_ready_o); else n_pass++;
    tick;
    b_valid_i = 0;
    n_total++; if (we_o !== 1'b1 || rd_addr_o !== 5'd2 || rd_o !== 32'h22)
      $display("FAIL tie_write_b got we=%b addr=%0d data=%h exp 1 2 22", we_o, rd_addr_o, rd_o); else n_pass++;
    n_total++; if (conflict_o !== 1'b0) $display("FAIL tie_conflict_clear got %b exp 0", conflict_o); else n_pass++;
    tick;
    n_total++; if (we_o !== 1'b0) $display("FAIL tie_idle got %b exp 0", we_o); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int a_idx = 0;
    int b_idx = 0;
    logic exp_a;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    a_valid_i = 1; b_valid_i = 1;
    for (int k = 0; k < 6; k++) begin
      a_addr_i = 5'(8 + a_idx);  a_data_i = 32'hA000 + 32'(a_idx);
      b_addr_i = 5'(16 + b_idx); b_data_i = 32'hB000 + 32'(b_idx);
      exp_a = (k % 2 == 0);
      exp_addr = exp_a ? 5'(8 + a_idx) : 5'(16 + b_idx);
      exp_data = exp_a ? 32'hA000 + 32'(a_idx) : 32'hB000 + 32'(b_idx);
      #1;
      n_total++; if (a_ready_o !== exp_a || b_ready_o !== !exp_a)
        $display("FAIL b2b_grant k=%0d got a=%b b=%b exp %b %b", k, a_ready_o, b_ready_o, exp_a, !exp_a);
      else n_pass++;
      tick;
      if (exp_a) a_idx++; else b_idx++;
      n_total++; if (we_o !== 1'b1 || rd_addr_o !== exp_addr || rd_o !== exp_data)
        $display("FAIL b2b_write k=%0d got we=%b addr=%0d data=%h exp 1 %0d %h", k, we_o, rd_addr_o, rd_o, exp_addr, exp_data);
      else n_pass++;
      n_total++; if (conflict_o !== 1'b1) $display("FAIL b2b_conflict k=%0d got %b exp 1", k, conflict_o); else n_pass++;
    end
    a_valid_i = 0; b_valid_i = 0;
    tick;
    n_total++; if (we_o !== 1'b0 || conflict_o !== 1'b0)
      $display("FAIL b2b_drain got we=%b conflict=%b exp 0 0", we_o, conflict_o); else n_pass++;
  endtask

  task automatic test_reset_mid_init;
    rst_n_i = 1'b0;
    tick;
    rst_n_i = 1'b1;
    for (int i = 1; i <= 10; i++) tick;
    n_total++; if (we_o !== 1'b1 || rd_addr_o !== 5'd10)
      $display("FAIL mid_pre got we=%b addr=%0d exp 1 10", we_o, rd_addr_o); else n_pass++;
    rst_n_i = 1'b0;
    #1;
    n_total++; if (we_o !== 1'b0 || rd_addr_o !== 5'd0 || init_done_o !== 1'b0)
      $display("FAIL mid_async got we=%b addr=%0d done=%b exp 0 0 0", we_o, rd_addr_o, init_done_o); else n_pass++;
    tick;
    rst_n_i = 1'b1;
    // A request raised during the clear must wait, then be served first in ARB.
    a_valid_i = 1; a_addr_i = 5'd7; a_data_i = 32'h77;
    for (int i = 1; i <= 31; i++) begin
      #1;
      n_total++; if (a_ready_o !== 1'b0) $display("FAIL mid_hold_ready i=%0d got %b exp 0", i, a_ready_o); else n_pass++;
      tick;
      n_total++; if (we_o !== 1'b1 || rd_addr_o !== 5'(i) || rd_o !== 32'd0 || conflict_o !== 1'b0)
        $display("FAIL mid_write i=%0d got we=%b addr=%0d data=%h cf=%b exp 1 %0d 0 0", i, we_o, rd_addr_o, rd_o, conflict_o, i);
      else n_pass++;
      n_total++; if (init_done_o !== (i == 31))
        $display("FAIL mid_done i=%0d got %b exp %b", i, init_done_o, (i == 31)); else n_pass++;
    end
    #1;
    n_total++; if (a_ready_o !== 1'b1) $display("FAIL mid_served_ready got %b exp 1", a_ready_o); else n_pass++;
    tick;
    a_valid_i = 0;
    n_total++; if (we_o !== 1'b1 || rd_addr_o !== 5'd7 || rd_o !== 32'h77)
      $display("FAIL mid_served_write got we=%b addr=%0d data=%h exp 1 7 77", we_o, rd_addr_o, rd_o); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_init;
    test_single_a;
    test_zero_addr;
    test_tie;
    test_back_to_back;
    test_reset_mid_init;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
